// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: the shared memory read port plus the decode-side instruction handshake.
// The fetch unit connects through the master view and the memory/decode side through the slave view.
interface fetch_unit_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
);
   logic                  mem_grant;
   logic [ADDR_WIDTH-1:0] mem_address;
   logic [DATA_WIDTH-1:0] mem_val;
   logic                  redirect;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic [DATA_WIDTH-1:0] instr;
   logic [ADDR_WIDTH-1:0] instr_pc;
   logic                  instr_valid;
   logic                  instr_ready;
   logic [ADDR_WIDTH-1:0] pc;

   modport master (
      input  mem_grant, mem_val, redirect, redirect_pc, instr_ready,
      output mem_address, instr, instr_pc, instr_valid, pc
   );

   modport slave (
      output mem_grant, mem_val, redirect, redirect_pc, instr_ready,
      input  mem_address, instr, instr_pc, instr_valid, pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one-cycle memory read tracking and a 2-entry instruction buffer.
// Optional FETCH_BYPASS_EN presents the returning word directly to decode when the buffer is empty.
module fetch_unit #(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic         clock,
   input  logic         reset,
   fetch_unit_if.master bus
);
   logic [ADDR_WIDTH-1:0] pc_reg;
   logic                  pending_reg;
   logic [ADDR_WIDTH-1:0] pending_pc_reg;
   logic [1:0]            count_reg;
   logic [DATA_WIDTH-1:0] word_reg  [2];
   logic [ADDR_WIDTH-1:0] addr_reg  [2];
   logic [DATA_WIDTH-1:0] word_next [2];
   logic [ADDR_WIDTH-1:0] addr_next [2];

   logic       bypass;
   logic       head_valid;
   logic       pop;
   logic       push;
   logic       shift;
   logic       issue;
   logic [2:0] occ;
   logic [1:0] wr_slot;

`ifdef FETCH_BYPASS_EN
   assign bypass = (count_reg == 2'd0) & pending_reg & ~bus.redirect;
`else
   assign bypass = 1'b0;
`endif

   assign head_valid = (count_reg != 2'd0) | bypass;
   assign pop        = head_valid & bus.instr_ready & ~bus.redirect;

   // Occupancy after this cycle, counting the read in flight as already buffered.
   assign occ   = {1'b0, count_reg} + {2'b0, pending_reg} - {2'b0, pop};
   assign issue = bus.mem_grant & ~bus.redirect & (occ < 3'd2);

   // A bypassed word that is accepted in its capture cycle never enters the buffer.
   assign push    = pending_reg & ~bus.redirect & ~(bypass & pop);
   assign shift   = pop & (count_reg == 2'd2);
   assign wr_slot = count_reg - {1'b0, pop};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_entry
         logic load;
         assign load = push & (wr_slot == 2'(gi));
         assign word_next[gi] = load ? bus.mem_val :
                                ((gi == 0) && shift) ? word_reg[1] : word_reg[gi];
         assign addr_next[gi] = load ? pending_pc_reg :
                                ((gi == 0) && shift) ? addr_reg[1] : addr_reg[gi];
      end
   endgenerate

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_reg         <= RESET_PC;
         pending_reg    <= 1'b0;
         pending_pc_reg <= '0;
         count_reg      <= 2'd0;
         word_reg       <= '{default: '0};
         addr_reg       <= '{default: '0};
      end else begin
         if (bus.redirect) begin
            pc_reg      <= bus.redirect_pc;
            count_reg   <= 2'd0;
            pending_reg <= 1'b0;
         end else begin
            count_reg   <= occ[1:0];
            pending_reg <= issue;
            if (issue) begin
               pending_pc_reg <= pc_reg;
               pc_reg         <= pc_reg + ADDR_WIDTH'(1);
            end
         end
         word_reg <= word_next;
         addr_reg <= addr_next;
      end
   end

   assign bus.mem_address = pc_reg;
   assign bus.pc          = pc_reg;
   assign bus.instr_valid = head_valid;
   assign bus.instr       = bypass ? bus.mem_val    : word_reg[0];
   assign bus.instr_pc    = bypass ? pending_pc_reg : addr_reg[0];
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: synchronous-read memory model and an in-order scoreboard
// of expected fetch addresses that is drained as decode accepts instructions.
module tb_fetch_unit;
`ifdef FETCH_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic clock = 1'b0;
   logic reset;

   fetch_unit_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

   fetch_unit #(
      .DATA_WIDTH(16),
      .ADDR_WIDTH(16),
      .RESET_PC  (16'h0000)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.master)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] word_at(input logic [15:0] a);
      case (a)
         16'h0000: word_at = 16'h0008;
         16'h0001: word_at = 16'h0814;
         16'h0002: word_at = 16'h8014;
         16'h0003: word_at = 16'h8838;
         default:  word_at = a ^ 16'h5A5A;
      endcase
   endfunction

   always @(posedge clock) bus.mem_val <= word_at(bus.mem_address);

   int err_cnt = 0;
   int chk_cnt = 0;
   int cyc = 0;
   int first_xfer_cyc = -1;
   int last_xfer_cyc = -1;
   int c0;
   logic [15:0] exp_pc;
   logic [15:0] exp_q [$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Inspect the handshake mid-cycle; a transfer happens at the coming rising edge.
   task automatic monitor();
      logic [15:0] a;
      if (reset && bus.instr_valid && bus.instr_ready && !bus.redirect) begin
         $display("xfer cyc=%0d instr_pc=%h instr=%h", cyc, bus.instr_pc, bus.instr);
         check_val("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            a = exp_q.pop_front();
            check_val("instr_pc", 32'(bus.instr_pc), 32'(a));
            check_val("instr", 32'(bus.instr), 32'(word_at(a)));
         end
         if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
         last_xfer_cyc = cyc;
      end
   endtask

   task automatic tick();
      @(negedge clock);
      monitor();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic drain(input int max_cycles);
      int n = 0;
      while (exp_q.size() > 0 && n < max_cycles) begin
         tick();
         n++;
      end
      check_val("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      bus.instr_ready = 1'b0;
   endtask

   initial begin
      reset           = 1'b0;
      bus.mem_grant   = 1'b0;
      bus.instr_ready = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 16'h0000;

      // Reset values
      @(posedge clock);
      #1;
      check_val("rst_pc", 32'(bus.pc), 32'h0);
      check_val("rst_mem_address", 32'(bus.mem_address), 32'h0);
      check_val("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
      check_val("rst_instr", 32'(bus.instr), 32'h0);
      check_val("rst_instr_pc", 32'(bus.instr_pc), 32'h0);

      // Reset then stream at full rate
      reset           = 1'b1;
      bus.mem_grant   = 1'b1;
      bus.instr_ready = 1'b1;
      c0 = cyc;
      first_xfer_cyc = -1;
      for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));
      drain(30);
      check_val("stream_first_cyc", 32'(first_xfer_cyc - c0), 32'(LAT));
      check_val("stream_last_cyc", 32'(last_xfer_cyc - c0), 32'(LAT + 3));

      // Fill the buffer, then assert reset between clock edges
      for (int i = 0; i < 4; i++) tick();
      check_val("full_valid", 32'(bus.instr_valid), 32'd1);
      check_val("full_head_pc", 32'(bus.instr_pc), 32'h4);
      #2;
      reset = 1'b0;
      #1;
      check_val("async_valid", 32'(bus.instr_valid), 32'd0);
      check_val("async_pc", 32'(bus.pc), 32'h0);
      check_val("async_mem_address", 32'(bus.mem_address), 32'h0);
      @(posedge clock);
      #1;
      reset = 1'b1;

      // Backpressure from reset: two entries buffered, pc stalls at 2
      for (int i = 0; i < 5; i++) tick();
      check_val("bp_pc", 32'(bus.pc), 32'h2);
      check_val("bp_mem_address", 32'(bus.mem_address), 32'h2);
      check_val("bp_valid", 32'(bus.instr_valid), 32'd1);
      check_val("bp_head_pc", 32'(bus.instr_pc), 32'h0);
      for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));
      bus.instr_ready = 1'b1;
      drain(20);

      // Grant gaps: pc advances only on granted cycles
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0020;
      tick();
      bus.redirect = 1'b0;
      check_val("gap_redirect_pc", 32'(bus.pc), 32'h20);
      exp_pc = 16'h0020;
      for (int i = 0; i < 4; i++) exp_q.push_back(16'h0020 + 16'(i));
      bus.instr_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.mem_grant = (i % 2 == 0);
         tick();
         if (i % 2 == 0) exp_pc = exp_pc + 16'd1;
         check_val("gap_pc", 32'(bus.pc), 32'(exp_pc));
      end
      bus.mem_grant = 1'b0;
      drain(20);

      // Redirect one cycle after issuing address 5
      bus.mem_grant   = 1'b1;
      bus.instr_ready = 1'b1;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0005;
      tick();
      bus.redirect = 1'b0;
      tick();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0010;
      tick();
      bus.redirect = 1'b0;
      check_val("redir_flushed", 32'(bus.instr_valid), 32'd0);
      check_val("redir_pc", 32'(bus.pc), 32'h10);
      for (int i = 0; i < 3; i++) exp_q.push_back(16'h0010 + 16'(i));
      c0 = cyc;
      first_xfer_cyc = -1;
      drain(20);
      check_val("redir_first_cyc", 32'(first_xfer_cyc - c0), 32'(LAT));

      // PC wrap past 16'hFFFF
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'hFFFF;
      tick();
      bus.redirect = 1'b0;
      exp_q.push_back(16'hFFFF);
      exp_q.push_back(16'h0000);
      exp_q.push_back(16'h0001);
      bus.instr_ready = 1'b1;
      drain(20);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the 16-bit word-addressed `memory` block. It owns the program counter, drives the memory read address, captures the synchronously-read word one cycle later, and delivers instructions to decode through a 2-entry buffer with a valid/ready handshake. It yields the shared memory port to the data stage whenever the grant is deasserted, and it supports a redirect for branches and jumps.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `DATA_WIDTH`, 16, instruction/word width.
- `ADDR_WIDTH`, 16, address and PC width.
- `clock  in  1`: single clock; all state updates on the rising edge.
- `reset  in  1`: asynchronous, active-low; 0 clears all state immediately.
- `mem_grant  in  1`: 1 = fetch may issue a read this cycle; 0 = the data stage owns the port, including every `MemWrite` cycle.
- `mem_address  out  ADDR_WIDTH`: read address, always equal to `pc`.
- `mem_val  in  DATA_WIDTH`: memory read data, valid one cycle after issue.
- `redirect  in  1`: load new PC and flush.
- `redirect_pc  in  ADDR_WIDTH`: target for redirect.
- `instr  out  DATA_WIDTH`: head instruction.
- `instr_pc  out  ADDR_WIDTH`: address of the head instruction.
- `instr_valid  out  1`: head entry is valid.
- `instr_ready  in  1`: decode accepts the head; a transfer occurs when valid and ready are both 1.
- `pc  out  ADDR_WIDTH`: next fetch address.

## Operation
- State:
  - `pc`
  - 2-entry FIFO of {word, addr}
  - `count` (0..2)
  - `pending` flag plus `pending_pc` for the read in flight.
- **Issue:** `issue = mem_grant & ~redirect & (count + pending - pop < 2)`, where `pop = instr_valid & instr_ready & ~redirect`.
  - On issue: `pending <= 1`, `pending_pc <= pc`, `pc <= pc + 1`.
  - Otherwise `pending <= 0`.
- **Capture:** when `pending = 1`, `mem_val` is pushed with tag `pending_pc`.
  - Push and pop may occur in the same cycle; `count` is then unchanged.
- **PC arithmetic:** modulo 2^16; 16'hFFFF + 1 = 16'h0000. Out-of-range addresses are passed through unchanged; memory size is the memory's concern.
- **Redirect** has top priority:
  - `pc <= redirect_pc`; `count <= 0`; `pending <= 0`, so the word returning next cycle is discarded.
  - No issue occurs, and any handshake that cycle is void (not a transfer).
- **Grant low:** no issue; the in-flight capture still completes.
- **Full buffer** (`count + pending = 2` with no pop): issue stalls and `pc` holds.
- **Empty buffer:** `instr_valid = 0`; `instr` and `instr_pc` hold their last values.
- **Reset asserted mid-operation:** the buffer, `pending`, and `pc` clear immediately. The outstanding memory read is ignored after release.

## Timing
- Reset values:
  - `pc` = `mem_address` = `RESET_PC`
  - `instr_valid` = 0, `instr` = 0, `instr_pc` = 0
  - `count` = 0, `pending` = 0
- Issue in cycle N → `mem_val` valid in N+1 → push at end of N+1 → `instr_valid` in N+2 (2-cycle fetch latency, without bypass).
- Sustained throughput: 1 instruction per cycle while grant = 1 and decode is ready.
- First issue occurs in the first cycle after reset release with grant = 1.
- Redirect in cycle R → first issue at `redirect_pc` in R+1 → `instr_valid` earliest at R+3 (R+2 with bypass).

## Configuration
- `FETCH_BYPASS_EN`
  - **Defined:** when the FIFO is empty and `pending = 1` (and no redirect), `instr = mem_val`, `instr_pc = pending_pc`, and `instr_valid = 1` combinationally in the capture cycle. If accepted that cycle, the word is not pushed. Latency is 1 cycle.
  - **Undefined:** all outputs come from the FIFO registers; latency is 2 cycles.

## Test plan
- **Reset then stream:** release reset with grant = 1 and ready = 1, memory preloaded with words[0..3] = 16'h0008, 16'h0814, 16'h8014, 16'h8838 → instr/instr_pc = (16'h0008, 0), (16'h0814, 1), … on consecutive cycles, first valid at cycle 2 (cycle 1 with bypass).
- **Backpressure:** ready = 0 for 5 cycles → exactly 2 entries are buffered, `pc` stalls at 2 and `mem_address` holds 2. Raising ready releases addresses 0 then 1 with no loss or duplication.
- **Grant gaps:** toggle grant 1,0,1,0 → one issue per granted cycle only, in-order delivery, and `pc` advances only on granted cycles.
- **Redirect with read in flight:** redirect to 16'h0010 one cycle after issuing address 5 → the word from address 5 is never presented, the buffer is emptied, and the next delivered instruction has `instr_pc` = 16'h0010.
- **Wrap:** redirect to 16'hFFFF → delivered `instr_pc` sequence is 16'hFFFF, 16'h0000, 16'h0001.
- **Async reset mid-stream:** pull reset low between clock edges while count = 2 → `instr_valid` = 0 and `pc` = `RESET_PC` immediately. The previously issued read is not delivered after release.
